// File: rtl/riscv_icache.sv
// riscv_icache: direct-mapped instruction cache with 16-byte (4-word) lines.
// A hit returns the word in the same cycle. A miss refills the whole line
// from backing memory, one word per acknowledged beat, and then hits on the
// next IDLE cycle.
// Optional build macro RISCV_ICACHE_STATS_EN adds the hit_count/miss_count outputs.
// Ports:
//   clk, rst                     clock, async active-high reset
//   imem_addr_valid, imem_addr   hart fetch request (byte address)
//   imem_data_ready, imem_data   fetch word valid / instruction word
//   flush                        invalidate all lines (fence.i)
//   mem_req, mem_addr            backing word read request / word address
//   mem_ack, mem_rdata           backing beat delivered / read data
//   hit_count, miss_count        (stats build only) event counters
`timescale 1ns/1ps

module riscv_icache #(
  parameter int unsigned LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_addr_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_data_ready,
  output logic [31:0] imem_data,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef RISCV_ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned BASE_W = 28;
  localparam int unsigned TAG_W  = BASE_W - IDX_W;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                drop_q, drop_d;

  // Tag and data arrays are not reset; the valid bits qualify them.
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES][4];

  logic [1:0]          req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    ref_idx;
  logic                lookup_hit;
  logic                data_we;
  logic                tag_we;
  logic                refill_start;
  logic                unused_addr_lsb;

  assign req_off         = imem_addr[3:2];
  assign req_idx         = imem_addr[4 +: IDX_W];
  assign req_tag         = imem_addr[31 -: TAG_W];
  assign ref_idx         = base_q[IDX_W-1:0];
  assign unused_addr_lsb = ^imem_addr[1:0];

  // Next-state, refill control and the zero-cycle hit path.
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    base_d          = base_q;
    valid_d         = valid_q;
    drop_d          = drop_q;
    data_we         = 1'b0;
    tag_we          = 1'b0;
    refill_start    = 1'b0;
    lookup_hit      = 1'b0;
    imem_data_ready = 1'b0;
    imem_data       = data_q[req_idx][req_off];
    mem_req         = 1'b0;
    mem_addr        = 32'h0;

    case (state_q)
      IDLE: begin
        lookup_hit = imem_addr_valid && valid_q[req_idx] &&
                     (tag_q[req_idx] == req_tag);
        if (flush) begin
          valid_d = '0;
        end else if (imem_addr_valid && !lookup_hit) begin
          // The line is overwritten beat by beat, so it is invalid until it completes.
          base_d           = imem_addr[31:4];
          beat_d           = 2'd0;
          drop_d           = 1'b0;
          valid_d[req_idx] = 1'b0;
          state_d          = REFILL;
          refill_start     = 1'b1;
        end else if (lookup_hit) begin
          imem_data_ready = 1'b1;
        end
      end

      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {base_q, beat_q, 2'b00};
        // A flush mid-refill finishes the handshake but discards the line.
        if (flush) begin
          valid_d = '0;
          drop_d  = 1'b1;
        end
        if (mem_ack) begin
          data_we = 1'b1;
          beat_d  = 2'(beat_q + 2'd1);
          if (beat_q == 2'd3) begin
            tag_we  = 1'b1;
            state_d = IDLE;
            if (!flush && !drop_q) begin
              valid_d[ref_idx] = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state; reset abandons any refill in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      base_q  <= '0;
      valid_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Line storage writes.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[ref_idx][beat_q] <= mem_rdata;
    end
    if (tag_we) begin
      tag_q[ref_idx] <= base_q[BASE_W-1 -: TAG_W];
    end
  end

`ifdef RISCV_ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Event counters wrap naturally at 2^32.
  always_comb begin
    hit_count_d  = hit_count_q + 32'(imem_data_ready);
    miss_count_d = miss_count_q + 32'(refill_start);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_riscv_icache.sv
// tb_riscv_icache: directed scoreboard bench for riscv_icache (LINES=16).
// Stimulus pushes expected backing addresses and fetch words into queues;
// a monitor pops and compares whenever the DUT shows a beat or a ready word.
`timescale 1ns/1ps

module tb_riscv_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_addr_valid;
  logic [31:0] imem_addr;
  logic        imem_data_ready;
  logic [31:0] imem_data;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef RISCV_ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int lat   = 0;
  int cnt   = 0;

  logic [31:0] exp_mem[$];
  logic [31:0] exp_fetch[$];

  riscv_icache #(.LINES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr_valid (imem_addr_valid),
    .imem_addr       (imem_addr),
    .imem_data_ready (imem_data_ready),
    .imem_data       (imem_data),
    .flush           (flush),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
`ifdef RISCV_ICACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Backing memory contents: each word carries its own low address bits.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE0000 | {16'h0000, a[15:0]};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endfunction

  function automatic void push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_mem.push_back(base + 32'(4 * i));
  endfunction

  // Backing memory: acks after 'lat' wait cycles, or in the request cycle when lat=0.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        mem_ack = 1'b0;
        cnt     = 0;
      end else if (lat == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        cnt     = 1;
      end else if (cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
      end else begin
        cnt++;
      end
    end
  end

  // Monitor: one sample per cycle, just before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (mem_req && mem_ack) begin
        if (exp_mem.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL mem_beat: got unexpected beat at %08h, expected none", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, exp_mem.pop_front());
        end
      end
      if (imem_data_ready) begin
        if (exp_fetch.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL imem_data: got unexpected ready word %08h, expected none", imem_data);
        end else begin
          chk("imem_data", imem_data, exp_fetch.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Caller is at a sample point; counts cycles until ready.
  task automatic wait_ready(output int n);
    n = 0;
    forever begin
      if (imem_data_ready) break;
      n++;
      if (n > 300) begin
        n_vec++;
        n_bad++;
        $display("FAIL fetch_timeout: got no ready at %08h, expected ready", imem_addr);
        break;
      end
      @(negedge clk);
      #4;
    end
  endtask

  task automatic fetch(input logic [31:0] a, output int n);
    @(negedge clk);
    imem_addr       = a;
    imem_addr_valid = 1'b1;
    #4;
    wait_ready(n);
  endtask

  // Waits (sampling mid-cycle) for a refill beat address to appear.
  task automatic wait_mem_addr(input logic [31:0] a);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_req && mem_addr == a) break;
      n++;
      if (n > 300) begin
        n_vec++;
        n_bad++;
        $display("FAIL mem_wait_timeout: got %08h, expected %08h", mem_addr, a);
        break;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    imem_addr_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst             = 1'b1;
    imem_addr_valid = 1'b0;
    imem_addr       = 32'h0;
    flush           = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_ready", 32'(imem_data_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss on 0x100, ack in request cycle.
    push_line(32'h100);
    exp_fetch.push_back(32'hC0DE0100);
    fetch(32'h100, n);
    chk("cold_miss_latency", 32'(n), 32'd5);

    // Same-line hits, one per cycle.
    exp_fetch.push_back(32'hC0DE0104);
    fetch(32'h104, n);
    chk("hit_latency_104", 32'(n), 32'd0);
    exp_fetch.push_back(32'hC0DE0108);
    fetch(32'h108, n);
    chk("hit_latency_108", 32'(n), 32'd0);
    exp_fetch.push_back(32'hC0DE010C);
    fetch(32'h10C, n);
    chk("hit_latency_10c", 32'(n), 32'd0);

    // Conflict eviction at index 0.
    push_line(32'h200);
    exp_fetch.push_back(32'hC0DE0200);
    fetch(32'h200, n);
    push_line(32'h100);
    exp_fetch.push_back(32'hC0DE0100);
    fetch(32'h100, n);
    chk("evict_refill_latency", 32'(n), 32'd5);
    idle();
`ifdef RISCV_ICACHE_STATS_EN
    #1;
    chk("miss_count", miss_count, 32'd3);
    chk("hit_count", hit_count, 32'd6);
`endif

    // Flush in IDLE suppresses a would-be hit and starts no refill.
    @(negedge clk);
    imem_addr       = 32'h100;
    imem_addr_valid = 1'b1;
    flush           = 1'b1;
    #4;
    chk("flush_idle_ready", 32'(imem_data_ready), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    #4;
    chk("flush_idle_no_req", 32'(mem_req), 32'h0);
    push_line(32'h100);
    exp_fetch.push_back(32'hC0DE0100);
    fetch(32'h100, n);

    // Flush at beat 1 of a slow refill: the line is refilled twice.
    lat = 2;
    push_line(32'h300);
    push_line(32'h300);
    exp_fetch.push_back(32'hC0DE0300);
    fork
      fetch(32'h300, n);
      begin
        wait_mem_addr(32'h304);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    lat = 0;

    // Reset at beat 2 abandons the refill immediately.
    push_line(32'h400);
    void'(exp_mem.pop_back());
    void'(exp_mem.pop_back());
    @(negedge clk);
    imem_addr       = 32'h400;
    imem_addr_valid = 1'b1;
    wait_mem_addr(32'h408);
    rst             = 1'b1;
    imem_addr_valid = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    chk("rst_mid_ready", 32'(imem_data_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_line(32'h400);
    exp_fetch.push_back(32'hC0DE0400);
    fetch(32'h400, n);
    chk("post_rst_refill_latency", 32'(n), 32'd5);

    // Address moves to another line during refill.
    push_line(32'h500);
    push_line(32'h610);
    exp_fetch.push_back(32'hC0DE0610);
    @(negedge clk);
    imem_addr       = 32'h500;
    imem_addr_valid = 1'b1;
    wait_mem_addr(32'h500);
    imem_addr = 32'h610;
    #2;
    wait_ready(n);
    exp_fetch.push_back(32'hC0DE0504);
    fetch(32'h504, n);
    chk("kept_line_hit_latency", 32'(n), 32'd0);

    // No ready without a request.
    @(negedge clk);
    imem_addr_valid = 1'b0;
    #4;
    chk("no_valid_ready", 32'(imem_data_ready), 32'h0);

`ifdef RISCV_ICACHE_STATS_EN
    @(negedge clk);
    force dut.hit_count_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.hit_count_q;
    exp_fetch.push_back(32'hC0DE0504);
    fetch(32'h504, n);
    idle();
    #1;
    chk("hit_count_wrap", hit_count, 32'h0);
`endif

    idle();
    repeat (3) @(negedge clk);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'h0);
    chk("fetch_queue_drained", 32'(exp_fetch.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_icache.md
RISCV_ICACHE -- requirements
Module: riscv_icache

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of two, >=2).
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_addr_valid  input  1  hart fetch request.
REQ-005 SHALL have port imem_addr  input  32  hart fetch byte address; bits [1:0] ignored.
REQ-006 SHALL have port imem_data_ready  output  1  fetch word valid this cycle.
REQ-007 SHALL have port imem_data  output  32  fetched instruction word.
REQ-008 SHALL have port flush  input  1  invalidate all lines (fence.i).
REQ-009 SHALL have port mem_req  output  1  backing read request.
REQ-010 SHALL have port mem_addr  output  32  backing word address, bits [1:0] = 0.
REQ-011 SHALL have port mem_ack  input  1  backing word delivered this cycle.
REQ-012 SHALL have port mem_rdata  input  32  backing read data, valid when mem_ack=1.

Function
REQ-013 SHALL use 16-byte lines of 4 words: offset = addr[3:2], index = addr[3+log2(LINES):4], tag = remaining upper bits; per line one valid bit, tag, 4 data words.
REQ-014 SHALL implement FSM states IDLE and REFILL.
REQ-015 SHALL, in IDLE with imem_addr_valid=1 and valid+tag match at index, drive imem_data_ready=1 and imem_data = stored word combinationally in the same cycle (zero-cycle hit).
REQ-016 SHALL drive imem_data_ready=0 in REFILL, in IDLE on a miss, and whenever imem_addr_valid=0; imem_data is don't-care then.
REQ-017 SHALL, in IDLE on a miss with imem_addr_valid=1 and flush=0, latch the line base address (addr[31:4]) and enter REFILL next cycle with beat counter 0.
REQ-018 SHALL, in REFILL, hold mem_req=1 and mem_addr = line base + 4*beat until mem_ack; on each mem_ack write mem_rdata into word[beat] and increment beat.
REQ-019 SHALL, on the ack of beat 3, write tag, set valid (unless dropped per REQ-022), deassert mem_req next cycle and return to IDLE; the hart's held address then hits on the first IDLE cycle.
REQ-020 SHALL keep mem_req=0 in IDLE; no new request before return to IDLE (one outstanding refill).
REQ-021 SHALL, on flush=1 in IDLE, clear all valid bits on that edge and report imem_data_ready=0 that cycle; no refill starts that cycle.
REQ-022 SHALL, on flush=1 in REFILL, clear all valid bits, continue the refill to beat 3 (handshake not abandoned), and leave the refilled line invalid.
REQ-023 SHALL tolerate imem_addr changing during REFILL: the latched line completes, then IDLE lookup uses the current imem_addr.
REQ-024 SHALL accept mem_ack held high continuously: one beat per cycle, 4-cycle refill minimum.

Reset
REQ-025 SHALL, while rst=1, clear all valid bits, set FSM IDLE, beat 0, mem_req=0, imem_data_ready=0, mem_addr=0, immediately without a clock edge.
REQ-026 SHALL abandon an in-progress refill on rst; partially written line remains invalid.
REQ-027 SHALL NOT reset data/tag arrays.

Configuration
REQ-028 SHALL, with macro RISCV_ICACHE_STATS_EN defined, add outputs hit_count (32) and miss_count (32), reset to 0, incremented by 1 per cycle with imem_data_ready=1 and per IDLE->REFILL transition respectively, wrapping modulo 2^32.
REQ-029 SHALL, without RISCV_ICACHE_STATS_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-030 Cold miss: after reset, imem_addr=0x00000100, mem_ack same cycle as req -> mem_addr 0x100,0x104,0x108,0x10C on 4 consecutive cycles; ready=1 with word 0 data on next cycle.
REQ-031 Same-line hits: after REQ-030, addrs 0x104,0x108,0x10C -> ready=1 each cycle, zero mem_req, data = beats 1..3.
REQ-032 Conflict eviction (LINES=16): fetch 0x100 then 0x200 (same index 0) then 0x100 -> three refills; miss_count=3 with stats on.
REQ-033 Flush during refill: assert flush for 1 cycle at beat 1 of 0x300 refill, mem_ack delayed 2 cycles per beat -> 4 beats still complete, then 0x300 misses again and re-refills.
REQ-034 Reset mid-refill: assert rst at beat 2 -> mem_req=0 immediately; after release, fetch of same line issues full 4-beat refill.
REQ-035 Stats wrap: force hit_count to 0xFFFFFFFF, one hit -> hit_count=0x00000000.
